tagger_pattern_gen: RTL and testbench

TAGGER_PATTERN_GEN -- requirements
Module: tagger_pattern_gen

---
 rtl/tagger_pkg.sv | 14 +
 rtl/tagger_pattern_gen_if.sv | 26 ++
 rtl/tagger_pattern_gen.sv | 123 ++++++++++++
 tb/tb_tagger_pattern_gen.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/tagger_pkg.sv
// Shared definitions for the tagger pattern generator: FSM state encoding and
// the fine-bin count derived from the subtime width.
package tagger_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int fine_of(input int bits);
        return 1 << bits;
    endfunction

endpackage

// File: rtl/tagger_pattern_gen_if.sv
// Control/config and tagger-stream bundle of the pattern generator.
// The master drives start/stop/config; the slave (generator) drives the stream.
interface tagger_pattern_gen_if #(
    parameter int BITS      = 3,
    parameter int CONF_BITS = 16
);
    logic                 start;
    logic                 stop;
    logic [CONF_BITS-1:0] conf_period;
    logic [CONF_BITS-1:0] conf_offset;
    logic [CONF_BITS-1:0] conf_count;
    logic [BITS-1:0]      out_subtimes;
    logic                 out_edge_detected;
    logic                 busy;
    logic                 done;

    modport master (
        output start, stop, conf_period, conf_offset, conf_count,
        input  out_subtimes, out_edge_detected, busy, done
    );

    modport slave (
        input  start, stop, conf_period, conf_offset, conf_count,
        output out_subtimes, out_edge_detected, busy, done
    );
endinterface

// File: rtl/tagger_pattern_gen.sv
// Periodic edge generator producing a tagger subtimes/edge_detected stream.
// Optional macro TAGGER_PATTERN_CNT_EN adds a saturating edge_total output.
module tagger_pattern_gen
    import tagger_pkg::*;
#(
    parameter int BITS      = 3,
    parameter int CONF_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tagger_pattern_gen_if.slave  bus
`ifdef TAGGER_PATTERN_CNT_EN
    ,
    output logic [31:0]          edge_total
`endif
);

    localparam int                   FINE   = fine_of(BITS);
    localparam int                   RW     = CONF_BITS + 1;
    localparam logic [RW-1:0]        FINE_R = RW'(FINE);
    localparam logic [CONF_BITS-1:0] FINE_C = CONF_BITS'(FINE);

    state_t               state_q, state_d;
    logic [RW-1:0]        remaining_q, remaining_d;
    logic [CONF_BITS-1:0] period_q, period_d;
    logic [CONF_BITS-1:0] count_q, count_d;
    logic [CONF_BITS-1:0] edge_cnt_q, edge_cnt_d;
    logic [BITS-1:0]      subtimes_q, subtimes_d;
    logic                 edge_q, edge_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        period_d    = period_q;
        count_d     = count_q;
        edge_cnt_d  = edge_cnt_q;
        subtimes_d  = '0;
        edge_d      = 1'b0;
        done_d      = 1'b0;
        busy_d      = (state_q == RUN);
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = RUN;
                    period_d    = (bus.conf_period < FINE_C) ? FINE_C : bus.conf_period;
                    remaining_d = {1'b0, bus.conf_offset};
                    count_d     = bus.conf_count;
                    edge_cnt_d  = '0;
                end
            end
            RUN: begin
                // stop takes priority over an edge falling in the same cycle
                if (bus.stop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (remaining_q < FINE_R) begin
                    edge_d      = 1'b1;
                    subtimes_d  = remaining_q[BITS-1:0];
                    remaining_d = remaining_q + {1'b0, period_q} - FINE_R;
                    edge_cnt_d  = edge_cnt_q + CONF_BITS'(1);
                    if (count_q != '0 && edge_cnt_q == count_q - CONF_BITS'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    remaining_d = remaining_q - FINE_R;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            period_q    <= '0;
            count_q     <= '0;
            edge_cnt_q  <= '0;
            subtimes_q  <= '0;
            edge_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            period_q    <= period_d;
            count_q     <= count_d;
            edge_cnt_q  <= edge_cnt_d;
            subtimes_q  <= subtimes_d;
            edge_q      <= edge_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.out_subtimes      = subtimes_q;
    assign bus.out_edge_detected = edge_q;
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;

`ifdef TAGGER_PATTERN_CNT_EN
    logic [31:0] edge_total_q, edge_total_d;

    always_comb begin
        edge_total_d = edge_total_q;
        if (state_q == IDLE && bus.start)
            edge_total_d = '0;
        else if (edge_d && edge_total_q != '1)
            edge_total_d = edge_total_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_total_q <= '0;
        else        edge_total_q <= edge_total_d;
    end

    assign edge_total = edge_total_q;
`endif

endmodule

// File: tb/tb_tagger_pattern_gen.sv
// Self-checking bench for tagger_pattern_gen: an edge-schedule model computed
// from burst parameters, a per-cycle compare process, and literal spot checks.
module tb_tagger_pattern_gen;
    localparam int F   = 8;
    localparam int BIG = 1 << 20;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   cyc = 0;
    int   nchecks = 0;
    int   nerrors = 0;
    bit   go = 1'b0;

    tagger_pattern_gen_if #(.BITS(3), .CONF_BITS(16)) bus ();
`ifdef TAGGER_PATTERN_CNT_EN
    logic [31:0] edge_total;
`endif

    tagger_pattern_gen #(.BITS(3), .CONF_BITS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef TAGGER_PATTERN_CNT_EN
        ,
        .edge_total (edge_total)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // model state: one burst described by its parameters, cycles relative to start cycle
    bit m_active = 1'b0;
    int m_t0 = 0, m_P = F, m_O = 0, m_N = 0, m_stop = -1, m_prev_total = 0;

    function automatic int last_vis();
        if (m_N == 0) return BIG;
        return 2 + (m_O + (m_N - 1) * m_P) / F;
    endfunction

    function automatic bit stopped();
        return (m_stop >= 1) && (m_stop < last_vis());
    endfunction

    function automatic int lim_vis();
        return stopped() ? m_stop : last_vis();
    endfunction

    function automatic int done_cyc();
        if (stopped()) return m_stop + 1;
        return last_vis();
    endfunction

    function automatic bit find_j(input int r, output int j);
        int lo;
        lo = (r - 2) * F;
        if (m_O >= lo) j = 0;
        else           j = (lo - m_O + m_P - 1) / m_P;
        return (m_O + j * m_P < lo + F) && (m_N == 0 || j < m_N);
    endfunction

    function automatic int model_total(input int r);
        int rr, hi, n;
        if (!m_active || r <= 0) return m_prev_total;
        rr = (r < lim_vis()) ? r : lim_vis();
        if (rr < 2) return 0;
        hi = (rr - 1) * F;
        if (m_O >= hi) return 0;
        n = (hi - 1 - m_O) / m_P + 1;
        if (m_N > 0 && n > m_N) n = m_N;
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int h_edge[64], h_sub[64], h_busy[64], h_done[64], h_total[64];
    int cr, jj, e_edge, e_sub, e_busy, e_done, e_total;

    always @(negedge clk) begin
        if (go) begin
            cr = cyc - m_t0;
            e_edge = 0; e_sub = 0; e_busy = 0; e_done = 0;
            e_total = model_total(cr);
            if (m_active) begin
                if (cr >= 2 && cr <= lim_vis() && find_j(cr, jj)) begin
                    e_edge = 1;
                    e_sub  = (m_O + jj * m_P) % F;
                end
                e_busy = (cr >= 2 && cr <= done_cyc()) ? 1 : 0;
                e_done = (cr == done_cyc()) ? 1 : 0;
            end
            chk("edge", 32'(bus.out_edge_detected), 32'(e_edge));
            chk("subtimes", 32'(bus.out_subtimes), 32'(e_sub));
            chk("busy", 32'(bus.busy), 32'(e_busy));
            chk("done", 32'(bus.done), 32'(e_done));
`ifdef TAGGER_PATTERN_CNT_EN
            chk("edge_total", edge_total, 32'(e_total));
`endif
            if (cr >= 0 && cr < 64) begin
                h_edge[cr] = 32'(bus.out_edge_detected);
                h_sub[cr]  = 32'(bus.out_subtimes);
                h_busy[cr] = 32'(bus.busy);
                h_done[cr] = 32'(bus.done);
`ifdef TAGGER_PATTERN_CNT_EN
                h_total[cr] = edge_total;
`else
                h_total[cr] = 0;
`endif
            end
        end
    end

    // start in cycle 0; optional stop, second start and reset at given relative cycles
    task automatic run_burst(input int p, input int o, input int n, input int stop_at,
                             input int again_at, input int rst_at, input int len);
        @(posedge clk); #1;
        m_prev_total = m_active ? model_total(cyc - m_t0) : m_prev_total;
        m_P = (p < F) ? F : p; m_O = o; m_N = n;
        m_stop = (stop_at > 0) ? stop_at : -1;
        m_t0 = cyc; m_active = 1'b1;
        bus.start = 1'b1;
        bus.conf_period = 16'(p); bus.conf_offset = 16'(o); bus.conf_count = 16'(n);
        for (int c = 1; c <= len; c++) begin
            @(posedge clk); #1;
            bus.start = (c == again_at);
            bus.stop  = (c == stop_at);
            if (c == again_at) begin
                bus.conf_period = 16'd9; bus.conf_offset = 16'd2; bus.conf_count = 16'd7;
            end
            if (c == rst_at) begin
                rst_n = 1'b0; m_active = 1'b0; m_prev_total = 0;
                #1;
                chk("rst_edge", 32'(bus.out_edge_detected), 32'd0);
                chk("rst_busy", 32'(bus.busy), 32'd0);
                chk("rst_done", 32'(bus.done), 32'd0);
            end
            if (rst_at > 0 && c == rst_at + 3) rst_n = 1'b1;
        end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.stop = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0;
        bus.conf_period = '0; bus.conf_offset = '0; bus.conf_count = '0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_edge", 32'(bus.out_edge_detected), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        go = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // count=3 burst with an ignored restart at cycle 3
        run_burst(20, 5, 3, 0, 3, 0, 12);
        chk("t1_edge2", 32'(h_edge[2]), 32'd1); chk("t1_sub2", 32'(h_sub[2]), 32'd5);
        chk("t1_edge3", 32'(h_edge[3]), 32'd0);
        chk("t1_edge5", 32'(h_edge[5]), 32'd1); chk("t1_sub5", 32'(h_sub[5]), 32'd1);
        chk("t1_edge7", 32'(h_edge[7]), 32'd1); chk("t1_sub7", 32'(h_sub[7]), 32'd5);
        chk("t1_done7", 32'(h_done[7]), 32'd1); chk("t1_busy7", 32'(h_busy[7]), 32'd1);
        chk("t1_busy8", 32'(h_busy[8]), 32'd0); chk("t1_edge9", 32'(h_edge[9]), 32'd0);
`ifdef TAGGER_PATTERN_CNT_EN
        chk("t1_total8", 32'(h_total[8]), 32'd3);
`endif

        // clamped period, continuous, stopped at cycle 10
        run_burst(3, 0, 0, 10, 0, 0, 14);
        chk("t2_edge2", 32'(h_edge[2]), 32'd1); chk("t2_sub2", 32'(h_sub[2]), 32'd0);
        chk("t2_edge10", 32'(h_edge[10]), 32'd1); chk("t2_edge11", 32'(h_edge[11]), 32'd0);
        chk("t2_done10", 32'(h_done[10]), 32'd0); chk("t2_done11", 32'(h_done[11]), 32'd1);
`ifdef TAGGER_PATTERN_CNT_EN
        chk("t2_total1", 32'(h_total[1]), 32'd0);
`endif

        // single far edge; stop in IDLE afterwards is ignored
        run_burst(50, 100, 1, 16, 0, 0, 18);
        chk("t3_edge13", 32'(h_edge[13]), 32'd0); chk("t3_edge14", 32'(h_edge[14]), 32'd1);
        chk("t3_sub14", 32'(h_sub[14]), 32'd4); chk("t3_done14", 32'(h_done[14]), 32'd1);
        chk("t3_busy17", 32'(h_busy[17]), 32'd0);

        // stop in the cycle of the final edge suppresses it
        run_burst(20, 5, 3, 6, 0, 0, 10);
        chk("t4_edge7", 32'(h_edge[7]), 32'd0); chk("t4_done7", 32'(h_done[7]), 32'd1);

        // reset mid continuous run, then idle until the next start
        run_burst(8, 3, 0, 0, 0, 4, 10);
        chk("t5_busy9", 32'(h_busy[9]), 32'd0); chk("t5_edge9", 32'(h_edge[9]), 32'd0);

        run_burst(13, 7, 4, 0, 0, 0, 12);
        chk("t6_sub6", 32'(h_sub[6]), 32'd1); chk("t6_sub7", 32'(h_sub[7]), 32'd6);
        chk("t6_done7", 32'(h_done[7]), 32'd1);

        repeat (2) @(posedge clk);
        go = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
